// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: shares the single-port 256x1 map RAM between four requesters.
// Port 0 (map initialiser) has absolute priority. Ports 1-3 share the remaining
// cycles round-robin. Reads come back on a per-port one-hot valid strobe.
module map_ram_arbiter #(
  parameter int AW     = 8,  // {x[3:0], y[3:0]}
  parameter int RD_LAT = 1   // RAM read latency, 1 or 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [3:0]      wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic            rdata,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_data,
  output logic            ram_wren,
  input  logic            ram_q
);

  logic [3:0]    gnt_q, gnt_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_data_q, ram_data_d;
  logic          ram_wren_q, ram_wren_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;   // next round-robin candidate, always 1..3

  // One-hot mask of reads in flight; the last stage lines up with ram_q.
  logic [3:0]    rd_pipe_q [RD_LAT];

  logic [3:0]    elig;
  logic          win_vld;
  logic [1:0]    win_idx;

  // The port granted this cycle is masked so one request never wins twice.
  assign elig = req & ~gnt_q;

  // Winner: port 0 first, otherwise scan ports 1-3 from rr_ptr with wrap 3->1.
  always_comb begin
    logic [1:0] cand;
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = rr_ptr_q;
    if (elig[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!win_vld && elig[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
        cand = (cand == 2'd3) ? 2'd1 : cand + 2'd1;
      end
    end
  end

  // Next-state for the grant and the RAM command; address/data hold when idle.
  always_comb begin
    gnt_d      = 4'b0000;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    if (win_vld) begin
      gnt_d      = 4'b0001 << win_idx;
      ram_addr_d = addr[win_idx*AW +: AW];
      ram_data_d = wdata[win_idx];
      ram_wren_d = we[win_idx];
      if (win_idx != 2'd0) begin
        rr_ptr_d = (win_idx == 2'd3) ? 2'd1 : win_idx + 2'd1;
      end
    end
  end

  // Grant and RAM command registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
      gnt_q      <= 4'b0000;
      ram_addr_q <= '0;
      ram_data_q <= 1'b0;
      ram_wren_q <= 1'b0;
      rr_ptr_q   <= 2'd1;
    end else begin
      gnt_q      <= gnt_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Read-return pipeline: a granted read enters here and emerges with ram_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: this small array is reset on purpose, so reads in flight at reset are dropped.
      for (int i = 0; i < RD_LAT; i++) rd_pipe_q[i] <= 4'b0000;
    end else begin
      rd_pipe_q[0] <= ram_wren_q ? 4'b0000 : gnt_q;
      for (int i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign gnt      = gnt_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign rvalid   = rd_pipe_q[RD_LAT-1];
  assign rdata    = (|rvalid) & ram_q;

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Bench for map_ram_arbiter: requester drivers feed per-port transaction queues,
// a transaction-level model predicts grants and read data into scoreboards, and
// a monitor compares the DUT against them whenever it shows a grant or rvalid.
module tb_map_ram_arbiter;
  localparam int AW     = 8;
  localparam int RD_LAT = 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [3:0]      req = '0, we = '0, wdata = '0;
  logic [4*AW-1:0] addr = '0;
  logic [3:0]      gnt, rvalid;
  logic            rdata, ram_data, ram_wren, ram_q;
  logic [AW-1:0]   ram_addr;

  always #5 clk = ~clk;

  map_ram_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Behavioural single-port RAM with RD_LAT cycles of read latency.
  bit   ram_mem [256];
  logic q1, q2;
  always @(posedge clk) begin
    q1 <= ram_mem[ram_addr];
    q2 <= q1;
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
  end
  assign ram_q = (RD_LAT == 1) ? q1 : q2;

  typedef struct { logic w; logic [AW-1:0] a; logic d; } txn_t;
  typedef struct { int cyc; logic [3:0] mask; logic [AW-1:0] a; logic d; logic w; } gexp_t;
  typedef struct { int cyc; logic [3:0] mask; logic d; } rexp_t;

  txn_t  pq [4][$];   // pending transactions per requester
  gexp_t gq [$];      // expected grants, in order
  rexp_t rq [$];      // expected read returns, in order

  bit         model_mem [256];
  int         m_rr  = 1;
  logic [3:0] m_gnt = '0;
  int         cyc   = 0;
  int         n_err = 0, n_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: port 0 wins outright, else first eligible of the
  // rotated list rr, rr+1, ... over ports 1..3.
  function automatic int pick(input logic [3:0] e, input int rr);
    if (e[0]) return 0;
    for (int i = 0; i < 3; i++) begin
      int p;
      p = ((rr - 1 + i) % 3) + 1;
      if (e[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [3:0] e;
    int p;
    e = req & ~m_gnt;
    p = pick(e, m_rr);
    if (p < 0) begin
      m_gnt = '0;
    end else begin
      logic [AW-1:0] a;
      a = addr[p*AW +: AW];
      gq.push_back('{cyc + 1, 4'(1 << p), a, wdata[p], we[p]});
      if (!we[p]) rq.push_back('{cyc + 1 + RD_LAT, 4'(1 << p), model_mem[a]});
      else        model_mem[a] = wdata[p];
      if (p != 0) m_rr = (p % 3) + 1;
      m_gnt = 4'(1 << p);
    end
  endtask

  // Requesters: retire the head on gnt, present the next head, then predict.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        req = '0;
      end else begin
        for (int k = 0; k < 4; k++)
          if (gnt[k] && pq[k].size() != 0) pq[k].delete(0);
        for (int k = 0; k < 4; k++) begin
          if (pq[k].size() != 0) begin
            req[k]           = 1'b1;
            we[k]            = pq[k][0].w;
            addr[k*AW +: AW] = pq[k][0].a;
            wdata[k]         = pq[k][0].d;
          end else begin
            req[k]           = 1'b0;
            we[k]            = 1'($urandom);
            addr[k*AW +: AW] = AW'($urandom);
            wdata[k]         = 1'($urandom);
          end
        end
        model_step();
      end
    end
  end

  // Monitor: compare grant/RAM command and read returns against the scoreboards.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        gexp_t eg;
        rexp_t er;
        eg = '{0, 4'b0, '0, 1'b0, 1'b0};
        er = '{0, 4'b0, 1'b0};
        if (gq.size() != 0 && gq[0].cyc == cyc) eg = gq.pop_front();
        if (rq.size() != 0 && rq[0].cyc == cyc) er = rq.pop_front();
        if (gnt != 0 || eg.mask != 0) begin
          check("gnt", 32'(gnt), 32'(eg.mask));
          if (eg.mask != 0) begin
            check("ram_addr", 32'(ram_addr), 32'(eg.a));
            check("ram_data", 32'(ram_data), 32'(eg.d));
            check("ram_wren", 32'(ram_wren), 32'(eg.w));
          end
        end else begin
          check("idle_wren", 32'(ram_wren), 32'd0);
        end
        if (rvalid != 0 || er.mask != 0) begin
          check("rvalid", 32'(rvalid), 32'(er.mask));
          if (er.mask != 0) check("rdata", 32'(rdata), 32'(er.d));
        end
      end
    end
  end

  function automatic bit busy();
    bit b;
    b = (gq.size() != 0) || (rq.size() != 0);
    for (int k = 0; k < 4; k++) if (pq[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      n_err++;
      $display("FAIL idle_timeout: still busy after %0d cycles", n);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},      32'(gnt),      32'd0);
    check({tag, "_rvalid"},   32'(rvalid),   32'd0);
    check({tag, "_rdata"},    32'(rdata),    32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    check({tag, "_ram_wren"}, 32'(ram_wren), 32'd0);
  endtask

  task automatic push(input int k, input logic w, input logic [AW-1:0] a, input logic d);
    pq[k].push_back('{w, a, d});
  endtask

  initial begin
    int seen;
    // Reset state.
    repeat (3) @(negedge clk);
    #1 check_outputs_zero("reset");
    @(negedge clk);
    #2 resetn = 1'b1;

    // Map init stream on port 0: random walls, cell 0x35 forced to 1.
    for (int a = 0; a < 256; a++)
      push(0, 1'b1, AW'(a), (a == 'h35) ? 1'b1 : 1'($urandom));
    wait_idle(2000);

    // Single read of 0x35 by port 1.
    push(1, 1'b0, 8'h35, 1'b0);
    wait_idle(50);

    // Reset while a port 2 read is in flight.
    push(2, 1'b0, 8'h35, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (gnt[2]) seen = 1;
    end
    check("rst_read_granted", 32'(seen), 32'd1);
    #2 resetn = 1'b0;
    #1 check_outputs_zero("midrst");
    for (int k = 0; k < 4; k++) pq[k].delete();
    gq.delete();
    rq.delete();
    m_rr  = 1;
    m_gnt = '0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (4) @(posedge clk);

    // Round-robin from the reset pointer, twice.
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k < 4; k++) push(k, 1'b0, AW'($urandom), 1'b0);
      wait_idle(50);
    end

    // Write-then-read of 0x7A: set it to 1 first, then port 1 clears it while port 3 reads.
    push(0, 1'b1, 8'h7A, 1'b1);
    wait_idle(50);
    push(1, 1'b1, 8'h7A, 1'b0);
    push(3, 1'b0, 8'h7A, 1'b0);
    wait_idle(50);

    // Port 0 stream of writes against a port 2 read.
    for (int a = 0; a < 5; a++) push(0, 1'b1, AW'(a), 1'b1);
    push(2, 1'b0, 8'h03, 1'b0);
    wait_idle(50);

    // Random traffic on all ports.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      for (int k = 0; k < 4; k++)
        if (pq[k].size() < 2 && $urandom_range(0, 2) == 0)
          push(k, 1'($urandom), AW'($urandom), 1'($urandom));
    end
    wait_idle(500);

    check("grant_sb_empty", 32'(gq.size()), 32'd0);
    check("read_sb_empty",  32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
